// File: rtl/ram_4x4.sv
// Single-port 4x4 synchronous RAM: en=1 writes din into mem[addr], en=0 loads
// mem[addr] into the registered dout. Synchronous reset clears storage and dout.
module ram_4x4 #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_p0;

    // Stage p0: storage update or read-data capture, one operation per edge.
    // The read register holds its value across write cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dout_p0 <= '0;
        end else if (en) begin
            mem[addr] <= din;
        end else begin
            dout_p0 <= mem[addr];
        end
    end

    assign dout = dout_p0;

endmodule

// File: tb/tb_ram_4x4.sv
// Self-checking bench for ram_4x4: directed scenarios plus randomized traffic
// compared against an array-based reference model of the RAM.
module tb_ram_4x4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] addr;
    logic [3:0] din;
    logic [3:0] dout;

    int checks;
    int failures;

    // Reference model: plain storage array plus the last value read out.
    logic [3:0] mem_m [4];
    logic [3:0] dout_m;

    ram_4x4 #(.DATA_W(4), .ADDR_W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d required to complete", checks);
        $fatal(1, "timeout");
    end

    // Apply one operation at the falling edge, let it be sampled at the rising
    // edge, update the model, and return at the next falling edge.
    task automatic drive(input logic r, input logic e, input logic [1:0] a, input logic [3:0] d);
        rst  = r;
        en   = e;
        addr = a;
        din  = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) mem_m[i] = 4'b0000;
            dout_m = 4'b0000;
        end else if (e) begin
            mem_m[a] = d;
        end else begin
            dout_m = mem_m[a];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 2'd0, 4'hF);
        checks++;
        if (dout !== 4'b0000) begin
            failures++;
            $display("FAIL reset_dout: got %b expected %b", dout, 4'b0000);
        end
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 1'b0, a[1:0], 4'hA);
            checks++;
            if (dout !== 4'b0000) begin
                failures++;
                $display("FAIL reset_read addr=%0d: got %b expected %b", a, dout, 4'b0000);
            end
        end
    endtask

    task automatic test_write_read_all();
        logic [3:0] vals [4];
        vals[0] = 4'b1010; vals[1] = 4'b1100; vals[2] = 4'b0101; vals[3] = 4'b1111;
        for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, a[1:0], vals[a]);
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 1'b0, a[1:0], 4'h0);
            checks++;
            if (dout !== vals[a]) begin
                failures++;
                $display("FAIL write_read_all addr=%0d: got %b expected %b", a, dout, vals[a]);
            end
        end
    endtask

    task automatic test_dout_hold();
        drive(1'b0, 1'b0, 2'd1, 4'h0);
        checks++;
        if (dout !== 4'b1100) begin
            failures++;
            $display("FAIL hold_pre_read: got %b expected %b", dout, 4'b1100);
        end
        drive(1'b0, 1'b1, 2'd2, 4'b0011);
        checks++;
        if (dout !== 4'b1100) begin
            failures++;
            $display("FAIL hold_during_write: got %b expected %b", dout, 4'b1100);
        end
        drive(1'b0, 1'b0, 2'd2, 4'h0);
        checks++;
        if (dout !== 4'b0011) begin
            failures++;
            $display("FAIL hold_read_back: got %b expected %b", dout, 4'b0011);
        end
    endtask

    task automatic test_overwrite();
        drive(1'b0, 1'b1, 2'd1, 4'b1100);
        drive(1'b0, 1'b1, 2'd1, 4'b0110);
        drive(1'b0, 1'b0, 2'd1, 4'h0);
        checks++;
        if (dout !== 4'b0110) begin
            failures++;
            $display("FAIL overwrite_read: got %b expected %b", dout, 4'b0110);
        end
        drive(1'b0, 1'b0, 2'd0, 4'h0);
        checks++;
        if (dout !== 4'b1010) begin
            failures++;
            $display("FAIL overwrite_other_addr: got %b expected %b", dout, 4'b1010);
        end
        // Same-value write leaves contents unchanged.
        drive(1'b0, 1'b1, 2'd0, 4'b1010);
        drive(1'b0, 1'b0, 2'd0, 4'h0);
        checks++;
        if (dout !== 4'b1010) begin
            failures++;
            $display("FAIL same_value_write: got %b expected %b", dout, 4'b1010);
        end
    endtask

    task automatic test_reset_priority();
        for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, a[1:0], 4'(4'd5 + a));
        drive(1'b0, 1'b0, 2'd2, 4'h0);
        drive(1'b1, 1'b1, 2'd3, 4'b1001);
        checks++;
        if (dout !== 4'b0000) begin
            failures++;
            $display("FAIL rstprio_dout: got %b expected %b", dout, 4'b0000);
        end
        for (int a = 3; a >= 0; a--) begin
            drive(1'b0, 1'b0, a[1:0], 4'h0);
            checks++;
            if (dout !== 4'b0000) begin
                failures++;
                $display("FAIL rstprio_read addr=%0d: got %b expected %b", a, dout, 4'b0000);
            end
        end
    endtask

    task automatic test_write_then_read();
        drive(1'b0, 1'b1, 2'd3, 4'b1000);
        drive(1'b0, 1'b0, 2'd3, 4'h0);
        checks++;
        if (dout !== 4'b1000) begin
            failures++;
            $display("FAIL write_then_read: got %b expected %b", dout, 4'b1000);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, a[1:0], 4'(4'd9 - 2 * a));
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, k[1:0], 4'h0);
            checks++;
            if (dout !== 4'(4'd9 - 2 * (k % 4))) begin
                failures++;
                $display("FAIL back_to_back addr=%0d: got %b expected %b", k % 4, dout, 4'(4'd9 - 2 * (k % 4)));
            end
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       e;
        logic [1:0] a;
        logic [3:0] d;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 24) == 0);
            e = $urandom_range(0, 1) == 1;
            a = 2'($urandom_range(0, 3));
            d = 4'($urandom_range(0, 15));
            drive(r, e, a, d);
            checks++;
            if (dout !== dout_m) begin
                failures++;
                $display("FAIL random n=%0d rst=%0b en=%0b addr=%0d: got %b expected %b", n, r, e, a, dout, dout_m);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        dout_m   = 4'b0000;
        for (int i = 0; i < 4; i++) mem_m[i] = 4'b0000;
        rst  = 1'b1;
        en   = 1'b0;
        addr = 2'd0;
        din  = 4'h0;
        @(negedge clk);
        test_reset();
        test_write_read_all();
        test_dout_hold();
        test_overwrite();
        test_reset_priority();
        test_write_then_read();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
